// File: rtl/instr_encoder_writer_if.sv
// Request/memory bus of the instruction encoder/writer.
// The master drives symbolic instruction requests. The slave (the writer) returns
// req_ready and drives the instruction-memory write port.
interface instr_encoder_writer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [20:0]       req_imm;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output req_valid,
        output req_op,
        output req_rd,
        output req_rs1,
        output req_rs2,
        output req_imm,
        input  req_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_rd,
        input  req_rs1,
        input  req_rs2,
        input  req_imm,
        output req_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/instr_encoder_writer.sv
// Instruction encoder/writer: turns symbolic requests into RV32I words and writes
// them sequentially into a word-addressed instruction memory.
// Each legal request costs one WRITE cycle. Illegal ops, and requests made while
// the memory is full, only set the sticky error flag.
module instr_encoder_writer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    instr_encoder_writer_if.slave bus,
    output logic [ADDR_W:0]     count_o,
    output logic                full_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StFull
    } state_e;

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

    // Major opcodes
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcReg    = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [20:0]       imm;

    assign imm = bus.req_imm;

    // Combinational RV32I encoding of the presented request
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (bus.req_op)
            4'd0: enc_word = {imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, OpcLoad};
            4'd1: enc_word = {imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010, imm[4:0], OpcStore};
            4'd2: enc_word = {7'b0000000, bus.req_rs2, bus.req_rs1, 3'b000, bus.req_rd, OpcReg};
            4'd3: enc_word = {7'b0100000, bus.req_rs2, bus.req_rs1, 3'b000, bus.req_rd, OpcReg};
            4'd4: enc_word = {7'b0000000, bus.req_rs2, bus.req_rs1, 3'b111, bus.req_rd, OpcReg};
            4'd5: enc_word = {7'b0000000, bus.req_rs2, bus.req_rs1, 3'b110, bus.req_rd, OpcReg};
            4'd6: enc_word = {7'b0000000, bus.req_rs2, bus.req_rs1, 3'b010, bus.req_rd, OpcReg};
            4'd7: enc_word = {imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, OpcImm};
            4'd8: enc_word = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, 3'b000,
                              imm[4:1], imm[11], OpcBranch};
            4'd9: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, OpcJal};
            default: enc_legal = 1'b0;
        endcase
    end

    // Next-state logic: accept in IDLE, one WRITE cycle per word, park in FULL
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (enc_legal) begin
                        wdata_d = enc_word;
                        state_d = StWrite;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                count_d = count_q + CntOne;
                state_d = (count_d == DepthCnt) ? StFull : StIdle;
            end
            StFull: begin
                if (bus.req_valid) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset outranks clear, both restart from an empty memory
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (clear_i) begin
            state_q <= StIdle;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs; the strobe is suppressed while reset/clear abort an in-flight write
    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.mem_we    = (state_q == StWrite) && !reset_i && !clear_i;
        bus.mem_addr  = count_q[ADDR_W-1:0];
        bus.mem_wdata = wdata_q;
        count_o       = count_q;
        full_o        = (state_q == StFull);
        err_o         = err_q;
    end

endmodule
